// File: rtl/cp0_exc_handler_pkg.sv
// CP0 register numbers, ExcCode values and field positions shared by the exception sink.
package cp0_exc_handler_pkg;

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_SR      = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;
  localparam logic [4:0] REG_PRID    = 5'd15;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int SR_IE_BIT    = 0;
  localparam int SR_EXL_BIT   = 1;
  localparam int SR_IM_LO     = 10;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_BD_BIT = 31;

  typedef struct packed {
    logic [5:0] im;
    logic       exl;
    logic       ie;
  } sr_t;

  typedef struct packed {
    logic       bd;
    logic [5:0] ip;
    logic [4:0] exccode;
  } cause_t;

  function automatic logic [31:0] sr_word(input sr_t s);
    logic [31:0] w;
    w = '0;
    w[SR_IM_LO +: 6] = s.im;
    w[SR_EXL_BIT]    = s.exl;
    w[SR_IE_BIT]     = s.ie;
    return w;
  endfunction

  function automatic logic [31:0] cause_word(input cause_t c);
    logic [31:0] w;
    w = '0;
    w[CAUSE_BD_BIT]       = c.bd;
    w[CAUSE_IP_LO +: 6]   = c.ip;
    w[CAUSE_EXC_LO +: 5]  = c.exccode;
    return w;
  endfunction

endpackage

// File: rtl/cp0_trap_arbiter.sv
// Combinational interrupt/exception arbitration: interrupts win and report ExcCode 0.
// Zero latency, no state; EXL masks both sources.
module cp0_trap_arbiter
  import cp0_exc_handler_pkg::*;
(
  input  logic [5:0] irq,
  input  logic [5:0] im,
  input  logic       ie,
  input  logic       exl,
  input  logic [4:0] exccode_m,
  output logic       trap_req,
  output logic [4:0] exccode_sel
);

  logic int_req;
  logic exc_req;

  assign int_req     = (|(irq & im)) & ie & ~exl;
  assign exc_req     = (exccode_m != EXC_INT) & ~exl;
  assign trap_req    = int_req | exc_req;
  assign exccode_sel = int_req ? EXC_INT : exccode_m;

endmodule

// File: rtl/cp0_exc_handler.sv
// CP0 exception/interrupt sink at M stage: SR/Cause/EPC state, mfc0 read mux, zero-latency trap_req.
// Define CP0_TIMER_EN to add Count/Compare with the timer interrupt on IP[15].
module cp0_exc_handler
  import cp0_exc_handler_pkg::*;
#(
  parameter logic [31:0] PRID         = 32'h0000_5150,
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_m,
  input  logic        bd_m,
  input  logic [4:0]  exccode_m,
  input  logic [5:0]  hwint,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] din,
  input  logic        eret_m,
  output logic [31:0] dout,
  output logic [31:0] epc_out,
  output logic        trap_req,
  output logic [31:0] handler_pc
);

  sr_t         sr;
  cause_t      cause;
  logic [31:0] epc;
  logic [5:0]  irq;
  logic [4:0]  exccode_sel;
  logic [31:0] pc_al;
  logic [31:0] epc_trap;

`ifdef CP0_TIMER_EN
  logic [31:0] count;
  logic [31:0] compare;
  logic        timer_pend;

  assign irq = hwint | {timer_pend, 5'b0};

  always_ff @(posedge clk) begin
    if (reset) begin
      count      <= '0;
      compare    <= '0;
      timer_pend <= 1'b0;
    end else begin
      count <= (we && !trap_req && addr == REG_COUNT) ? din : count + 32'd1;
      // A Compare write acknowledges the timer even if it matches this cycle.
      if (we && !trap_req && addr == REG_COMPARE) begin
        compare    <= din;
        timer_pend <= 1'b0;
      end else if (count == compare) begin
        timer_pend <= 1'b1;
      end
    end
  end
`else
  assign irq = hwint;
`endif

  cp0_trap_arbiter u_arb (
    .irq         (irq),
    .im          (sr.im),
    .ie          (sr.ie),
    .exl         (sr.exl),
    .exccode_m   (exccode_m),
    .trap_req    (trap_req),
    .exccode_sel (exccode_sel)
  );

  assign pc_al    = pc_m & 32'hFFFF_FFFC;
  assign epc_trap = bd_m ? pc_al - 32'd4 : pc_al;

  always_ff @(posedge clk) begin
    if (reset) begin
      sr    <= '0;
      cause <= '0;
      epc   <= '0;
    end else begin
      cause.ip <= irq;
      if (trap_req) begin
        sr.exl        <= 1'b1;
        cause.bd      <= bd_m;
        cause.exccode <= exccode_sel;
        epc           <= epc_trap;
      end else begin
        if (we && addr == REG_SR) begin
          sr.im  <= din[SR_IM_LO +: 6];
          sr.exl <= din[SR_EXL_BIT];
          sr.ie  <= din[SR_IE_BIT];
        end
        if (we && addr == REG_EPC) epc <= {din[31:2], 2'b00};
        if (eret_m) sr.exl <= 1'b0;
      end
    end
  end

  always_comb begin
    dout = '0;
    case (addr)
      REG_SR:      dout = sr_word(sr);
      REG_CAUSE:   dout = cause_word(cause);
      REG_EPC:     dout = epc;
      REG_PRID:    dout = PRID;
`ifdef CP0_TIMER_EN
      REG_COUNT:   dout = count;
      REG_COMPARE: dout = compare;
`endif
      default:     dout = '0;
    endcase
  end

  assign epc_out    = epc;
  assign handler_pc = HANDLER_ADDR;

endmodule

// File: tb/tb_cp0_exc_handler.sv
// Directed and randomized bench for cp0_exc_handler against a word-level model of CP0 state.
module tb_cp0_exc_handler;
  import cp0_exc_handler_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] pc_m;
  logic        bd_m;
  logic [4:0]  exccode_m;
  logic [5:0]  hwint;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] din;
  logic        eret_m;
  logic [31:0] dout;
  logic [31:0] epc_out;
  logic        trap_req;
  logic [31:0] handler_pc;

  int checks   = 0;
  int failures = 0;

  cp0_exc_handler dut (
    .clk(clk), .reset(reset), .pc_m(pc_m), .bd_m(bd_m), .exccode_m(exccode_m),
    .hwint(hwint), .we(we), .addr(addr), .din(din), .eret_m(eret_m),
    .dout(dout), .epc_out(epc_out), .trap_req(trap_req), .handler_pc(handler_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model: architectural register words, updated per clock from the written rules.
  logic [31:0] m_sr, m_cause, m_epc;
  bit          m_ok = 1'b0;
`ifdef CP0_TIMER_EN
  logic [31:0] m_count, m_cmp;
  bit          m_tp;
`endif

  function automatic logic [5:0] m_lines();
`ifdef CP0_TIMER_EN
    return hwint | (m_tp ? 6'b100000 : 6'b0);
`else
    return hwint;
`endif
  endfunction

  function automatic bit m_int();
    return ((m_lines() & m_sr[15:10]) != 6'b0) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic bit m_trap();
    return m_int() || (exccode_m != 5'd0 && !m_sr[1]);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12: return m_sr;
      5'd13: return m_cause;
      5'd14: return m_epc;
      5'd15: return 32'h0000_5150;
`ifdef CP0_TIMER_EN
      5'd9:  return m_count;
      5'd11: return m_cmp;
`endif
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    bit         t, i;
    logic [5:0] lines;
    if (reset) begin
      m_sr = 0; m_cause = 0; m_epc = 0; m_ok = 1'b1;
`ifdef CP0_TIMER_EN
      m_count = 0; m_cmp = 0; m_tp = 0;
`endif
    end else if (m_ok) begin
      t = m_trap();
      i = m_int();
      lines = m_lines();
`ifdef CP0_TIMER_EN
      if (we && !t && addr == 5'd11) begin
        m_cmp = din;
        m_tp  = 1'b0;
      end else if (m_count == m_cmp) begin
        m_tp = 1'b1;
      end
      m_count = (we && !t && addr == 5'd9) ? din : m_count + 1;
`endif
      m_cause[15:10] = lines;
      if (t) begin
        m_sr[1]       = 1'b1;
        m_cause[31]   = bd_m;
        m_cause[6:2]  = i ? 5'd0 : exccode_m;
        m_epc         = (pc_m & ~32'h3) - (bd_m ? 32'd4 : 32'd0);
      end else begin
        if (we && addr == 5'd12) m_sr = din & 32'h0000_FC03;
        if (we && addr == 5'd14) m_epc = din & ~32'h3;
        if (eret_m) m_sr[1] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("trap_req", {31'b0, trap_req}, {31'b0, m_trap()});
      chk("dout", dout, m_read(addr));
      chk("epc_out", epc_out, m_epc);
      chk("handler_pc", handler_pc, 32'h0000_4180);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string nm);
    addr = a;
    #1;
    chk(nm, dout, exp);
  endtask

  task automatic idle();
    we = 0; eret_m = 0; exccode_m = 0; bd_m = 0;
  endtask

  logic [4:0] codes [4];
  logic [4:0] regs  [8];

  initial begin
    codes = '{EXC_ADEL, EXC_ADES, EXC_RI, EXC_OV};
    regs  = '{REG_COUNT, REG_COMPARE, REG_SR, REG_CAUSE, REG_EPC, REG_PRID, 5'd0, 5'd31};
    reset = 1; pc_m = 0; hwint = 0; addr = 0; din = 0;
    idle();
    cyc(); cyc();
    reset = 0;
    // Reset values, read before the first non-reset edge.
    rd(REG_SR, 32'h0, "rst_sr");
    rd(REG_CAUSE, 32'h0, "rst_cause");
    rd(REG_EPC, 32'h0, "rst_epc");
    rd(REG_PRID, 32'h0000_5150, "rst_prid");
    chk("rst_trap", {31'b0, trap_req}, 32'h0);
`ifdef CP0_TIMER_EN
    we = 1; addr = REG_COMPARE; din = 32'hFFFF_0000;
`endif
    cyc(); idle();

    // Enable IM[10] + IE, then raise hwint[0].
    we = 1; addr = REG_SR; din = 32'h0000_0401;
    cyc(); idle();
    hwint = 6'b000001; pc_m = 32'h2000;
    #1 chk("int_trap", {31'b0, trap_req}, 32'h1);
    cyc();
    rd(REG_CAUSE, 32'h0000_0400, "int_cause");
    rd(REG_SR, 32'h0000_0403, "int_sr");
    chk("int_epc", epc_out, 32'h2000);
    chk("int_exl_mask", {31'b0, trap_req}, 32'h0);

    // AdEL in a delay slot.
    hwint = 0; eret_m = 1;
    cyc(); idle();
    exccode_m = EXC_ADEL; pc_m = 32'h3008; bd_m = 1;
    #1 chk("adel_trap", {31'b0, trap_req}, 32'h1);
    cyc(); idle();
    chk("adel_epc", epc_out, 32'h3004);
    rd(REG_CAUSE, 32'h8000_0010, "adel_cause");
    rd(REG_SR, 32'h0000_0403, "adel_sr");
    chk("model_cause", m_cause, 32'h8000_0010);

    // Nested exception under EXL is dropped; eret clears EXL.
    exccode_m = EXC_OV; pc_m = 32'h5000;
    #1 chk("nest_trap", {31'b0, trap_req}, 32'h0);
    cyc(); idle();
    rd(REG_CAUSE, 32'h8000_0010, "nest_cause");
    chk("nest_epc", epc_out, 32'h3004);
    eret_m = 1;
    cyc(); idle();
    rd(REG_SR, 32'h0000_0401, "eret_sr");

    // Interrupt beats RI; simultaneous mtc0 EPC is discarded, mfc0 sees old EPC.
    hwint = 6'b000001; exccode_m = EXC_RI; we = 1; din = 32'h1234; pc_m = 32'h6000;
    #1 chk("prio_trap", {31'b0, trap_req}, 32'h1);
    rd(REG_EPC, 32'h3004, "prio_nobypass");
    cyc(); idle(); hwint = 0;
    chk("prio_epc", epc_out, 32'h6000);
    rd(REG_CAUSE, 32'h0000_0400, "prio_cause");
    chk("model_epc", m_epc, 32'h6000);

    // mtc0 under EXL (no trap): EPC aligned, Cause and PRId read-only.
    we = 1; addr = REG_EPC; din = 32'hABCD_1237;
    cyc(); idle();
    chk("mtc0_epc", epc_out, 32'hABCD_1234);
    we = 1; addr = REG_CAUSE; din = 32'hFFFF_FFFF;
    cyc(); idle();
    rd(REG_CAUSE, 32'h0, "mtc0_cause_ro");
    we = 1; addr = REG_PRID; din = 32'h0;
    cyc(); idle();
    rd(REG_PRID, 32'h0000_5150, "mtc0_prid_ro");
    rd(5'd3, 32'h0, "unmapped_rd");

    // Delay-slot EPC wraps below zero.
    eret_m = 1;
    cyc(); idle();
    exccode_m = EXC_ADES; pc_m = 32'h2; bd_m = 1;
    cyc(); idle();
    chk("wrap_epc", epc_out, 32'hFFFF_FFFC);
    rd(REG_CAUSE, 32'h8000_0014, "wrap_cause");

    // Reset overrides a simultaneous mtc0.
    reset = 1; we = 1; addr = REG_SR; din = 32'h0000_0401;
    cyc(); idle(); reset = 0;
    rd(REG_SR, 32'h0, "rst_over_sr");
    rd(REG_EPC, 32'h0, "rst_over_epc");

`ifdef CP0_TIMER_EN
    begin
      bit seen;
      we = 1; addr = REG_COMPARE; din = 32'd40;
      cyc();
      addr = REG_SR; din = 32'h0000_8001;
      cyc(); idle();
      seen = 0;
      for (int k = 0; k < 100 && !seen; k++) begin
        if (trap_req) seen = 1;
        else cyc();
      end
      chk("timer_trap", {31'b0, seen}, 32'h1);
      cyc();
      we = 1; addr = REG_COMPARE; din = 32'd100000;
      cyc(); idle();
      cyc();
      addr = REG_CAUSE;
      #1 chk("timer_ack", dout & 32'h8000, 32'h0);
    end
`endif

    for (int n = 0; n < 3000; n++) begin
      reset     = ($urandom_range(0, 199) == 0);
      hwint     = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'b0;
      exccode_m = ($urandom_range(0, 5) != 0) ? 5'd0 :
                  ($urandom_range(0, 1) != 0) ? codes[$urandom_range(0, 3)] : 5'($urandom);
      bd_m      = 1'($urandom);
      pc_m      = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      we        = ($urandom_range(0, 3) == 0);
      eret_m    = !we && ($urandom_range(0, 7) == 0);
      addr      = ($urandom_range(0, 3) != 0) ? regs[$urandom_range(0, 7)] : 5'($urandom);
      din       = $urandom;
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
